// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the ALU datapath and the sequential divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, result
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, result
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider; returns {remainder, quotient} with
// truncation toward zero and the remainder carrying the dividend's sign.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 sa, sa_nxt;
    logic                 sb, sb_nxt;
    logic [WIDTH-1:0]     rem, rem_nxt;
    logic [WIDTH-1:0]     quo, quo_nxt;
    logic [WIDTH-1:0]     dsr, dsr_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;
    logic                 dbz_q, dbz_nxt;
    logic [2*WIDTH-1:0]   result_q, result_nxt;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;

    // Magnitude in WIDTH bits; the most negative value wraps onto itself and reads as unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sa_nxt     = sa;
        sb_nxt     = sb;
        rem_nxt    = rem;
        quo_nxt    = quo;
        dsr_nxt    = dsr;
        done_nxt   = 1'b0;
        dbz_nxt    = dbz_q;
        result_nxt = result_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_nxt  = S_DONE;
                        result_nxt = {bus.dividend, {WIDTH{1'b1}}};
                        dbz_nxt    = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                        sa_nxt    = bus.dividend[WIDTH-1];
                        sb_nxt    = bus.divisor[WIDTH-1];
                        quo_nxt   = mag(bus.dividend);
                        dsr_nxt   = mag(bus.divisor);
                        rem_nxt   = '0;
                        cnt_nxt   = '0;
                        dbz_nxt   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (!diff[WIDTH]) begin
                    rem_nxt = diff[WIDTH-1:0];
                    quo_nxt = {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem_nxt = shifted[WIDTH-1:0];
                    quo_nxt = {quo[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                result_nxt = {(sa ? WIDTH'(-rem) : rem),
                              ((sa ^ sb) ? WIDTH'(-quo) : quo)};
                done_nxt   = 1'b1;
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                // Arriving from FIX the pulse is already up; a divide-by-zero raises it here instead.
                done_nxt  = ~done_q;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_FIX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sa       <= sa_nxt;
            sb       <= sb_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            dsr      <= dsr_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            dbz_q    <= dbz_nxt;
            result_q <= result_nxt;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.result      = result_q;
endmodule
